// File: rtl/data_memory_ls.sv
// RV32I load/store data memory: B/H/W accesses with sign/zero extension, a base-address
// window with range checking, and optional two-beat splitting of word-crossing accesses.
module data_memory_ls #(
   parameter int unsigned   AW          = 32,
   parameter logic [AW-1:0] BASE        = '0,
   parameter int unsigned   DEPTH       = 1024,
   parameter bit            MISALIGN_EN = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] address,
   input  logic          read,
   input  logic          write,
   input  logic [2:0]    size,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata,
   output logic          rvalid,
   output logic          err,
   output logic          ready
);

   localparam int unsigned IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] SPAN = (AW+1)'(64'(DEPTH) * 64'd4);

   // Handshake: a request is taken on a rising edge where (read|write) & ready;
   // the answer is a one-cycle rvalid (with rdata) or err pulse, never both.
   typedef enum logic [0:0] {IDLE, SPLIT} state_t;

   state_t        state_q, state_d;
   logic [31:0]   mem [DEPTH];

   // Request decode
   logic          req, accept;
   logic [1:0]    lane;
   logic [2:0]    nbytes;
   logic [3:0]    bmask;
   logic [31:0]   wdata_m;
   logic [AW:0]   off, last;
   logic          size_ok, in_range, aligned, crossing, bad;
   logic [IW-1:0] widx, widx1;
   logic [63:0]   wd64;
   logic [7:0]    be64;

   // Second-beat context, captured at acceptance
   logic          sp_write;
   logic [IW-1:0] sp_idx;
   logic [3:0]    sp_be;
   logic [31:0]   sp_wd;
   logic [31:0]   sp_lo;
   logic [1:0]    sp_lane;
   logic [2:0]    sp_size;

   // Next-state / output decode
   logic          mem_we;
   logic [IW-1:0] mem_idx;
   logic [3:0]    mem_be;
   logic [31:0]   mem_wd;
   logic [31:0]   rdata_d;
   logic          rvalid_d, err_d;

   function automatic logic [31:0] fmt_load(input logic [63:0] pair,
                                            input logic [1:0]  ln,
                                            input logic [2:0]  sz);
      logic [31:0] v;
      v = 32'(pair >> {ln, 3'b000});
      case (sz)
         3'b000:  fmt_load = {{24{v[7]}}, v[7:0]};
         3'b001:  fmt_load = {{16{v[15]}}, v[15:0]};
         3'b100:  fmt_load = {24'b0, v[7:0]};
         3'b101:  fmt_load = {16'b0, v[15:0]};
         default: fmt_load = v;
      endcase
   endfunction

   assign ready  = (state_q == IDLE);
   assign req    = read | write;
   assign accept = req & ready & ~rst;

   always_comb begin
      lane    = address[1:0];
      nbytes  = 3'd4;
      bmask   = 4'b1111;
      wdata_m = wdata;
      case (size[1:0])
         2'b00: begin
            nbytes  = 3'd1;
            bmask   = 4'b0001;
            wdata_m = {24'b0, wdata[7:0]};
         end
         2'b01: begin
            nbytes  = 3'd2;
            bmask   = 4'b0011;
            wdata_m = {16'b0, wdata[15:0]};
         end
         default: ;
      endcase
      size_ok  = size inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      // An address below BASE wraps into the top bit and fails the span compare.
      off      = {1'b0, address} - {1'b0, BASE};
      last     = off + (AW+1)'(nbytes - 3'd1);
      in_range = (off < SPAN) && (last < SPAN);
      aligned  = (size[1:0] == 2'b00) ||
                 ((size[1:0] == 2'b01) && !address[0]) ||
                 ((size[1:0] == 2'b10) && (lane == 2'b00));
      crossing = ({1'b0, lane} + nbytes) > 3'd4;
      bad      = (read && write) || !size_ok || (write && size[2]) || !in_range ||
                 (!MISALIGN_EN && !aligned);
      widx     = off[IW+1:2];
      widx1    = widx + IW'(1);
      // Low half of the shifted data/enables targets word w, high half word w+1.
      wd64     = {32'b0, wdata_m} << {lane, 3'b000};
      be64     = {4'b0, bmask} << lane;
   end

   always_comb begin
      state_d  = state_q;
      mem_we   = 1'b0;
      mem_idx  = widx;
      mem_be   = be64[3:0];
      mem_wd   = wd64[31:0];
      rdata_d  = rdata;
      rvalid_d = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (bad) begin
                  err_d = 1'b1;
               end else if (write) begin
                  mem_we = 1'b1;
                  if (crossing) state_d = SPLIT;
               end else if (crossing) begin
                  state_d = SPLIT;
               end else begin
                  rvalid_d = 1'b1;
                  rdata_d  = fmt_load({32'b0, mem[widx]}, lane, size);
               end
            end
         end
         SPLIT: begin
            state_d = IDLE;
            if (sp_write) begin
               mem_we  = 1'b1;
               mem_idx = sp_idx;
               mem_be  = sp_be;
               mem_wd  = sp_wd;
            end else begin
               rvalid_d = 1'b1;
               rdata_d  = fmt_load({mem[sp_idx], sp_lo}, sp_lane, sp_size);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rdata   <= '0;
         rvalid  <= 1'b0;
         err     <= 1'b0;
      end else begin
         state_q <= state_d;
         rdata   <= rdata_d;
         rvalid  <= rvalid_d;
         err     <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         sp_write <= write;
         sp_idx   <= widx1;
         sp_be    <= be64[7:4];
         sp_wd    <= wd64[63:32];
         sp_lo    <= mem[widx];
         sp_lane  <= lane;
         sp_size  <= size;
      end
   end

   // Array is deliberately not reset; a reset in SPLIT drops the pending beat.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         for (int i = 0; i < 4; i++) begin
            if (mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_wd[8*i +: 8];
         end
      end
   end

endmodule

// File: doc/data_memory_ls.md
# data_memory_ls

Parametrised RV32I load/store data memory: the successor to the single-cycle `data_memory`, adding byte/halfword/word access sizes, sign/zero extension, a base-address window with range checking, and optional hardware splitting of word-crossing misaligned accesses over two beats. It sits behind the execute stage of the rv32i core. Requests are presented with `read`/`write`, qualified by `ready`, and answered with a registered `rdata`/`rvalid` or `err`.

## Interface
- `BASE`, 0: byte address of memory word 0; must be 4-byte aligned.
- `AW`, 32: address width.
- `DEPTH`, 1024: number of 32-bit words. Memory spans bytes `BASE` .. `BASE+4*DEPTH-1`.
- `MISALIGN_EN`, 1: 1 = split word-crossing accesses in hardware; 0 = every non-naturally-aligned access is an error.

- `clk` input 1: clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `address` input AW: byte address of the access.
- `read` input 1: load request.
- `write` input 1: store request.
- `size` input 3: RV32I funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `wdata` input 32: store data; only the low 8/16/32 bits are used, per `size`.
- `rdata` output 32: load result, extended to 32 bits; reset value 0.
- `rvalid` output 1: one-cycle pulse; `rdata` is valid. Reset value 0.
- `err` output 1: one-cycle pulse; the request was rejected. Reset value 0.
- `ready` output 1: block can accept a request. Combinational from state; 1 in IDLE and during reset.

## Operation
- Accept: a request is accepted on a rising edge where `(read|write) & ready`. Inputs are ignored while `ready`=0.
- Error checks, all evaluated at acceptance. Any failure gives an `err` pulse, no memory change and no `rvalid`:
  - `read & write` both high.
  - `size` not in {000, 001, 010, 100, 101}.
  - `write` with `size` 100 or 101.
  - First or last byte of the access is outside the memory span.
  - `MISALIGN_EN`=0 and the address is not naturally aligned (H: `address[0]`=0; W: `address[1:0]`=0).
- Addressing:
  - Word index = `(address-BASE)>>2`.
  - Lane = `address[1:0]`.
  - Byte order is little-endian: lane 0 = bits 7:0.
- Stores: write only the addressed byte lanes; other lanes keep their value.
- Loads:
  - B and H: sign-extend from bit 7 / bit 15.
  - BU and HU: zero-extend.
  - Halfword at lane 1 lies within one word and is a single beat.
- Split: an access whose bytes cross a word boundary (H at lane 3; W at lane ≠ 0) is split when `MISALIGN_EN`=1.
  - Beat 1 (acceptance edge): lanes lane..3 of word w.
  - Beat 2 (next edge): lanes 0..(lane+nbytes-5) of word w+1.
- FSM: IDLE → SPLIT on acceptance of a crossing access. SPLIT → IDLE unconditionally on the next edge. `ready`=0 in SPLIT.
- Read-after-write: a load accepted the cycle after a store to the same bytes returns the new data.
- Memory array is not reset; contents are undefined until written.
- Reset: asserting `rst` at any time forces IDLE, `rdata`=0, `rvalid`=0, `err`=0. A store interrupted in SPLIT keeps its committed beat 1; beat 2 is dropped.

## Timing
- Aligned load: accepted at edge N. `rdata`/`rvalid` are registered at edge N, sampled at N+1 (latency 1).
- Split load: accepted at edge N, second beat at N+1. `rvalid` is high after N+1 (latency 2).
- Aligned store: committed at edge N; `ready` stays 1, allowing back-to-back requests.
- Split store: words committed at edges N and N+1; `ready`=0 between edges N and N+1.
- `err`: high for one cycle after the accepting edge.
- `rvalid` and `err` are never high together. Stores produce neither unless in error.
- Throughput: one aligned request per cycle; one split request per two cycles.

## Test plan
- Sized loads (BASE=0, DEPTH=1024): SW 0x10 wdata 0xDEADBEEF, then the following loads, each with `rvalid` exactly 1 cycle after acceptance:
  - LW 0x10 → 0xDEADBEEF.
  - LB 0x13 → 0xFFFFFFDE.
  - LBU 0x13 → 0x000000DE.
  - LH 0x12 → 0xFFFFDEAD.
  - LHU 0x10 → 0x0000BEEF.
- Partial store: after the above, SB 0x11 wdata 0x12345678 → LW 0x10 returns 0xDEAD78EF.
- Split (MISALIGN_EN=1): SW 0x20 = 0 and SW 0x24 = 0, then SW 0x22 wdata 0xAABBCCDD.
  - `ready`=0 for one cycle.
  - LW 0x20 → 0xCCDD0000; LW 0x24 → 0x0000AABB.
  - LW 0x22 → 0xAABBCCDD with `rvalid` 2 cycles after acceptance.
- Errors, each → a single `err` pulse, no `rvalid`, memory unchanged (checked by readback):
  - LW 0x1000.
  - LW 0xFFE.
  - `size`=011.
  - `read` and `write` together.
  - SB with `size`=100.
  - `MISALIGN_EN`=0: LH 0x11.
- Reset mid-split: assert `rst` during SPLIT of SW 0x22 wdata 0xAABBCCDD, over zeroed words.
  - Outputs go to 0 and `ready` to 1 immediately, without waiting for a clock edge.
  - Afterwards LW 0x20 → 0xCCDD0000 and LW 0x24 → 0x00000000.
- Base window (BASE=0x1000_0000):
  - SW then LW at 0x1000_0004 round-trips 0x0000_0007.
  - LW 0x0000_0004 → `err`.
- Random regression: 10 seeded store/load pairs read from `seed.txt`.
  - Random size, random in-range address.
  - Load result compared against a byte-array model.
